// File: rtl/lcd_msg_sequencer.sv
// Feeds {rs, byte} words and a one-cycle start strobe to the LCD byte writer:
// HD44780 4-bit init after reset, then a full 2x16 redraw per accepted request.
module lcd_msg_sequencer #(
  parameter int TIMEOUT   = 4096,
  parameter bit SKIP_INIT = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       msg_valid,
  input  logic [2:0] msg_sel,
  input  logic [7:0] score,
  output logic       msg_ready,
  output logic       busy,
  output logic       timeout_err,
  output logic [8:0] lcd_data,
  output logic       lcd_start,
  input  logic       lcd_ready
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BCD,
    S_SEND,
    S_WAIT_CLR,
    S_WAIT_RDY
  } state_t;

  state_t        state, state_nx;
  logic          init_mode;
  logic [5:0]    idx;
  logic [TW-1:0] timer;
  logic [19:0]   bcd_sr;
  logic [2:0]    bcd_cnt;
  logic [2:0]    sel_q;
  logic          last_word;
  logic          timer_exp;
  logic [8:0]    word;
  logic [127:0]  line2;

  function automatic logic [7:0] line1_char(input logic [2:0] sel, input logic [3:0] pos);
    logic [127:0] txt;
    case (sel)
      3'd0:    txt = "SIMON SAYS      ";
      3'd1:    txt = "PRESS START     ";
      3'd2:    txt = "WATCH...        ";
      3'd3:    txt = "YOUR TURN       ";
      3'd4:    txt = "CORRECT!        ";
      3'd5:    txt = "WRONG-GAME OVER ";
      3'd6:    txt = "NEW HIGH SCORE  ";
      default: txt = "PAUSED          ";
    endcase
    return txt[8*(15 - int'(pos)) +: 8];
  endfunction

  // One double-dabble step: bias each BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dabble(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

  assign timer_exp = (timer == TIMER_LAST);
  assign last_word = init_mode ? (idx == 6'd5) : (idx == 6'd33);
  assign msg_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_comb begin
    word  = 9'h001;
    line2 = {"SCORE ",
             8'h30 + {4'h0, bcd_sr[19:16]},
             8'h30 + {4'h0, bcd_sr[15:12]},
             8'h30 + {4'h0, bcd_sr[11:8]},
             "       "};
    if (init_mode) begin
      case (idx)
        6'd0:    word = 9'h033;
        6'd1:    word = 9'h032;
        6'd2:    word = 9'h028;
        6'd3:    word = 9'h00C;
        6'd4:    word = 9'h006;
        default: word = 9'h001;
      endcase
    end else if (idx == 6'd0) begin
      word = 9'h080;
    end else if (idx <= 6'd16) begin
      word = {1'b1, line1_char(sel_q, 4'(idx - 6'd1))};
    end else if (idx == 6'd17) begin
      word = 9'h0C0;
    end else if (idx <= 6'd33) begin
      word = {1'b1, line2[8*(33 - int'(idx)) +: 8]};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (msg_valid) state_nx = S_BCD;
      S_BCD:      if (bcd_cnt == 3'd7) state_nx = S_SEND;
      S_SEND:     state_nx = S_WAIT_CLR;
      S_WAIT_CLR: state_nx = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (lcd_ready)      state_nx = last_word ? S_IDLE : S_SEND;
        else if (timer_exp) state_nx = S_IDLE;
      end
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= SKIP_INIT ? S_IDLE : S_SEND;
    else        state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      init_mode   <= !SKIP_INIT;
      idx         <= 6'd0;
      timer       <= '0;
      bcd_sr      <= 20'd0;
      bcd_cnt     <= 3'd0;
      sel_q       <= 3'd0;
      lcd_data    <= 9'h000;
      lcd_start   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (msg_valid) begin
            sel_q       <= msg_sel;
            bcd_sr      <= {12'd0, score};
            bcd_cnt     <= 3'd0;
            timeout_err <= 1'b0;
            init_mode   <= 1'b0;
            idx         <= 6'd0;
          end
        end
        S_BCD: begin
          bcd_sr  <= dabble(bcd_sr);
          bcd_cnt <= bcd_cnt + 3'd1;
        end
        S_SEND: begin
          lcd_data  <= word;
          lcd_start <= 1'b1;
          timer     <= '0;
        end
        S_WAIT_CLR: lcd_start <= 1'b0;
        S_WAIT_RDY: begin
          // lcd_data is left untouched on timeout so the stalled word stays visible.
          if (lcd_ready)      idx         <= idx + 6'd1;
          else if (timer_exp) timeout_err <= 1'b1;
          else                timer       <= timer + TW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Bench for lcd_msg_sequencer: table vectors, hand-written corner sequences,
// and randomized redraws checked against a string-level screen model.
module tb_lcd_msg_sequencer;

  localparam int TIMEOUT = 4096;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       msg_valid = 1'b0;
  logic [2:0] msg_sel = 3'd0;
  logic [7:0] score = 8'd0;
  logic       msg_ready, busy, timeout_err, lcd_start, lcd_ready;
  logic [8:0] lcd_data;

  logic wr_ready = 1'b1;
  logic wr_pend  = 1'b0;
  int   wr_cnt   = 0;
  int   wr_lat   = 20;
  bit   stuck     = 1'b0;
  bit   force_rdy = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [8:0] got[$];
  logic [8:0] exp_q[$];
  string      line1_txt[8];

  typedef struct {
    int    sel;
    int    sc;
    string l1;
    string dg;
  } vec_t;
  vec_t vecs[8];

  assign lcd_ready = force_rdy | wr_ready;

  lcd_msg_sequencer #(.TIMEOUT(TIMEOUT), .SKIP_INIT(1'b0)) dut (
    .clock       (clock),
    .reset       (reset),
    .msg_valid   (msg_valid),
    .msg_sel     (msg_sel),
    .score       (score),
    .msg_ready   (msg_ready),
    .busy        (busy),
    .timeout_err (timeout_err),
    .lcd_data    (lcd_data),
    .lcd_start   (lcd_start),
    .lcd_ready   (lcd_ready)
  );

  always #5 clock = ~clock;

  // Writer: ready drops the cycle after start, returns wr_lat cycles later.
  always @(posedge clock) begin
    if (lcd_start === 1'b1) begin
      wr_ready <= 1'b0;
      wr_pend  <= 1'b1;
      wr_cnt   <= wr_lat;
    end else if (wr_pend && !stuck) begin
      if (wr_cnt == 0) begin
        wr_ready <= 1'b1;
        wr_pend  <= 1'b0;
      end else begin
        wr_cnt <= wr_cnt - 1;
      end
    end
  end

  always @(negedge clock) begin
    if (lcd_start === 1'b1) got.push_back(lcd_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic check_stream(input string name);
    int bad;
    int n;
    bad = -1;
    check({name, "_len"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (bad < 0 && got[i] !== exp_q[i]) bad = i;
    n_chk++;
    if (bad < 0) n_pass++;
    else $display("FAIL %s word %0d: got %03h expected %03h", name, bad, got[bad], exp_q[bad]);
  endtask

  task automatic build_init();
    exp_q = '{9'h033, 9'h032, 9'h028, 9'h00C, 9'h006, 9'h001};
  endtask

  task automatic build_exp(input string l1, input string dg);
    string a;
    string b;
    a = l1;
    while (a.len() < 16) a = {a, " "};
    b = {"SCORE ", dg, "       "};
    exp_q = {};
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, a[i]});
    exp_q.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, b[i]});
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (msg_ready !== 1'b1 && n < bound);
    check({name, "_idle"}, msg_ready, 1'b1);
  endtask

  task automatic wait_words(input string name, input int k, input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (got.size() < k && n < bound);
    check({name, "_words"}, (got.size() >= k), 1'b1);
  endtask

  // Accept happens at the posedge; inputs are then scrambled to prove they were latched.
  task automatic send_msg(input int sel, input int sc);
    @(negedge clock);
    msg_valid = 1'b1;
    msg_sel   = 3'(sel);
    score     = 8'(sc);
    @(posedge clock);
    #1;
    msg_valid = 1'b0;
    msg_sel   = 3'($urandom);
    score     = 8'($urandom);
  endtask

  task automatic run_vec(input string name, input int sel, input int sc,
                         input string l1, input string dg);
    got = {};
    send_msg(sel, sc);
    wait_idle(name, 3000);
    build_exp(l1, dg);
    check_stream(name);
  endtask

  initial begin
    int n;
    int sel;
    int sc;
    string dg;

    line1_txt = '{"SIMON SAYS", "PRESS START", "WATCH...", "YOUR TURN",
                  "CORRECT!", "WRONG-GAME OVER", "NEW HIGH SCORE", "PAUSED"};
    vecs[0] = '{3, 142, "YOUR TURN", "142"};
    vecs[1] = '{0, 0, "SIMON SAYS", "000"};
    vecs[2] = '{5, 255, "WRONG-GAME OVER", "255"};
    vecs[3] = '{7, 7, "PAUSED", "007"};
    vecs[4] = '{1, 99, "PRESS START", "099"};
    vecs[5] = '{2, 100, "WATCH...", "100"};
    vecs[6] = '{4, 10, "CORRECT!", "010"};
    vecs[7] = '{6, 200, "NEW HIGH SCORE", "200"};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_lcd_data", lcd_data, 9'h000);
    check("rst_lcd_start", lcd_start, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_msg_ready", msg_ready, 1'b0);
    check("rst_busy", busy, 1'b1);

    got = {};
    reset = 1'b1;
    wait_idle("init", 2000);
    build_init();
    check_stream("init");
    check("init_busy", busy, 1'b0);
    check("init_timeout_err", timeout_err, 1'b0);

    for (int i = 0; i < 8; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].sel, vecs[i].sc, vecs[i].l1, vecs[i].dg);

    // Request while busy must be dropped without disturbing the stream.
    got = {};
    send_msg(3, 142);
    wait_words("ign", 5, 1000);
    @(negedge clock);
    msg_valid = 1'b1;
    msg_sel   = 3'd1;
    score     = 8'd99;
    repeat (3) @(negedge clock);
    msg_valid = 1'b0;
    wait_idle("ign", 3000);
    build_exp("YOUR TURN", "142");
    check_stream("ign");
    repeat (40) @(negedge clock);
    check("ign_no_extra", got.size(), 34);

    // Ready held high: 1 accept + 8 BCD + 34 words of 3 cycles.
    force_rdy = 1'b1;
    got = {};
    send_msg(0, 255);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (msg_ready !== 1'b1 && n < 500);
    check("latency", n, 111);
    build_exp("SIMON SAYS", "255");
    check_stream("fast");
    force_rdy = 1'b0;
    repeat (30) @(negedge clock);

    // Writer stalls on the first word.
    stuck = 1'b1;
    got = {};
    send_msg(2, 50);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (lcd_start !== 1'b1 && n < 100);
    check("to_first_start", lcd_start, 1'b1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (msg_ready !== 1'b1 && n < 6000);
    check("to_cycles", n, TIMEOUT + 1);
    check("to_err", timeout_err, 1'b1);
    check("to_ready", msg_ready, 1'b1);
    check("to_data_held", lcd_data, 9'h080);
    check("to_one_word", got.size(), 1);
    stuck = 1'b0;
    repeat (30) @(negedge clock);
    got = {};
    send_msg(4, 10);
    @(negedge clock);
    check("to_err_cleared", timeout_err, 1'b0);
    wait_idle("after_to", 3000);
    build_exp("CORRECT!", "010");
    check_stream("after_to");

    for (int r = 0; r < 8; r++) begin
      sel    = $urandom_range(0, 7);
      sc     = (r == 0) ? 255 : $urandom_range(0, 255);
      wr_lat = $urandom_range(0, 25);
      dg     = $sformatf("%0d%0d%0d", sc / 100, (sc / 10) % 10, sc % 10);
      run_vec($sformatf("rnd%0d", r), sel, sc, line1_txt[sel], dg);
    end
    wr_lat = 20;

    // Reset mid-message, with a request presented in the reset cycle.
    got = {};
    send_msg(6, 200);
    wait_words("mid", 21, 2000);
    @(negedge clock);
    reset     = 1'b0;
    msg_valid = 1'b1;
    @(negedge clock);
    check("mid_rst_data", lcd_data, 9'h000);
    check("mid_rst_start", lcd_start, 1'b0);
    check("mid_rst_busy", busy, 1'b1);
    check("mid_rst_ready", msg_ready, 1'b0);
    got       = {};
    reset     = 1'b1;
    msg_valid = 1'b0;
    wait_idle("reinit", 2000);
    build_init();
    check_stream("reinit");
    repeat (40) @(negedge clock);
    check("reinit_no_msg", got.size(), 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
